// File: rtl/multi_pulse_sync_pkg.sv
// Shared types and limits for the multi-channel pulse synchronizer.
package multi_pulse_sync_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;
    localparam int MAX_FILTER      = 255;
    localparam int MAX_CH          = 32;

    // True when a level update from old_lvl to new_lvl counts as an event for mode.
    function automatic logic edge_match(input edge_mode_e mode, input logic old_lvl,
                                        input logic new_lvl);
        logic changed;
        changed = (old_lvl != new_lvl);
        case (mode)
            EDGE_RISE: edge_match = changed && new_lvl;
            EDGE_FALL: edge_match = changed && !new_lvl;
            EDGE_BOTH: edge_match = changed;
            default:   edge_match = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multi_pulse_sync_sync_chain.sv
// Plain flop chain bringing one asynchronous bit into the i_clk domain.
module sync_chain #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    // Shift the input one stage per edge; pure wiring between stages.
    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], i_d};
    end

    // Chain registers, cleared asynchronously.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) sync_q <= '0;
        else       sync_q <= sync_d;
    end

    assign o_q = sync_q[DEPTH-1];

endmodule

// File: rtl/multi_pulse_sync.sv
// Multi-channel async input synchronizer with glitch filter, edge strobes,
// sticky flags and saturating event counters.
module multi_pulse_sync
    import multi_pulse_sync_pkg::*;
#(
    parameter int         NUM_CH        = 4,
    parameter int         SYNC_STAGES   = 2,
    parameter edge_mode_e EDGE_MODE     = EDGE_RISE,
    parameter int         FILTER_CYCLES = 0,
    parameter int         CNT_W         = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_CH-1:0]       i_async,
    input  logic [NUM_CH-1:0]       i_clr,
    output logic [NUM_CH-1:0]       o_level,
    output logic [NUM_CH-1:0]       o_pulse,
    output logic [NUM_CH-1:0]       o_sticky,
    output logic [NUM_CH*CNT_W-1:0] o_count
);

    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("multi_pulse_sync: NUM_CH out of range 1..32");
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
        $error("multi_pulse_sync: SYNC_STAGES out of range 2..4");
    end
    if (FILTER_CYCLES < 0 || FILTER_CYCLES > MAX_FILTER) begin : g_bad_filter
        $error("multi_pulse_sync: FILTER_CYCLES out of range 0..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("multi_pulse_sync: CNT_W must be at least 1");
    end

    // Filter count at which a pending change is accepted; 0 accepts immediately.
    localparam logic [7:0]       FILT_MATCH = 8'(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic             sync_out;
        logic             pending;
        logic             accept;
        logic [7:0]       filt_q,   filt_d;
        logic             level_q,  level_d;
        logic             pulse_q,  pulse_d;
        logic             sticky_q, sticky_d;
        logic [CNT_W-1:0] count_q,  count_d;
        logic [CNT_W-1:0] count_base;

        sync_chain #(
            .DEPTH (SYNC_STAGES)
        ) u_sync (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_d   (i_async[n]),
            .o_q   (sync_out)
        );

        // Filter: count consecutive pending cycles, accept the new level once the count hits the limit.
        always_comb begin
            pending = (sync_out != level_q);
            accept  = pending && (filt_q == FILT_MATCH);
            filt_d  = 8'd0;
            if (pending && !accept) filt_d = filt_q + 8'd1;
            level_d = accept ? sync_out : level_q;
            pulse_d = accept && edge_match(EDGE_MODE, level_q, sync_out);
        end

        // Event recording: clear takes effect first, then the registered strobe sets/increments.
        always_comb begin
            count_base = i_clr[n] ? '0 : count_q;
            sticky_d   = i_clr[n] ? 1'b0 : sticky_q;
            count_d    = count_base;
            if (pulse_q) begin
                sticky_d = 1'b1;
                if (count_base != CNT_MAX) count_d = count_base + CNT_W'(1);
            end
        end

        // Per-channel state registers, cleared asynchronously.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                filt_q   <= 8'd0;
                level_q  <= 1'b0;
                pulse_q  <= 1'b0;
                sticky_q <= 1'b0;
                count_q  <= '0;
            end else begin
                filt_q   <= filt_d;
                level_q  <= level_d;
                pulse_q  <= pulse_d;
                sticky_q <= sticky_d;
                count_q  <= count_d;
            end
        end

        assign o_level[n]                  = level_q;
        assign o_pulse[n]                  = pulse_q;
        assign o_sticky[n]                 = sticky_q;
        assign o_count[n*CNT_W +: CNT_W]   = count_q;
    end

endmodule

// File: doc/multi_pulse_sync.md
MULTI_PULSE_SYNC -- requirements
Module: multi_pulse_sync

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent asynchronous input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flop depth per channel (2..4).
REQ-003 Parameter EDGE_MODE, default EDGE_RISE, selects which transitions generate events: EDGE_RISE, EDGE_FALL or EDGE_BOTH.
REQ-004 Parameter FILTER_CYCLES, default 0, the number of consecutive cycles a synchronized change must persist before it is accepted (0 means no filtering; max 255).
REQ-005 Parameter CNT_W, default 8, width of each per-channel saturating event counter.
REQ-006 i_clk  input  1  sole clock; all logic is on its rising edge.
REQ-007 i_rst  input  1  reset, asynchronous and active-high.
REQ-008 i_async  input  NUM_CH  asynchronous level or pulse inputs, one bit per channel.
REQ-009 i_clr  input  NUM_CH  synchronous per-channel clear of the sticky flag and the counter.
REQ-010 o_level  output  NUM_CH  filtered, synchronized level of each channel.
REQ-011 o_pulse  output  NUM_CH  single-cycle event strobe per channel.
REQ-012 o_sticky  output  NUM_CH  per-channel event-seen flag.
REQ-013 o_count  output  NUM_CH*CNT_W  per-channel event counters, channel n occupying bits [n*CNT_W +: CNT_W].

Function
REQ-014 Each channel SHALL pass i_async[n] through a SYNC_STAGES-deep flop chain, with no logic between stages.
REQ-015 A change is pending when the last sync stage differs from o_level[n].
REQ-016 With FILTER_CYCLES=0, a pending change SHALL load o_level[n] on the next edge.
REQ-017 With FILTER_CYCLES=F>0, a per-channel filter counter SHALL count consecutive pending cycles, and o_level[n] SHALL load on the edge after the count reaches F.
REQ-018 The filter counter SHALL clear to 0 in any cycle where the change is not pending, so glitches shorter than F cycles produce no event.
REQ-019 An event SHALL be an o_level[n] update matching EDGE_MODE: 0->1 for RISE, 1->0 for FALL, either for BOTH.
REQ-020 o_pulse[n] SHALL be registered and high for exactly one cycle, in the same cycle o_level[n] takes its new value.
REQ-021 Latency, measured from the first i_clk edge sampling a stable new input to o_pulse/o_level high, SHALL be exactly SYNC_STAGES+1+FILTER_CYCLES edges.
REQ-022 An event SHALL set o_sticky[n] and increment o_count[n], both registered and visible in the cycle after o_pulse[n].
REQ-023 o_count[n] SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 i_clr[n] SHALL clear o_sticky[n] and o_count[n] on the next edge.
REQ-025 If i_clr[n] and an event are applied to the counter on the same edge, the result SHALL be o_sticky[n]=1 and o_count[n]=1: the clear applies first, then the event.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be recorded.
REQ-027 Input pulses shorter than one i_clk period, and transitions closer together than SYNC_STAGES+FILTER_CYCLES+1 cycles, are outside the contract: they may be lost, but SHALL never produce o_pulse wider than one cycle.

Reset
REQ-028 While i_rst is high, all sync flops, filter counters, o_level, o_pulse, o_sticky and o_count SHALL be 0, asynchronously.
REQ-029 After reset deasserts, an input already high SHALL be treated as a rising transition, with normal latency.
REQ-030 Reset asserted mid-filter or mid-pulse SHALL abort the event with no residual pulse.

Structure
REQ-031 Package multi_pulse_sync_pkg SHALL hold the edge_mode_e typedef (EDGE_RISE, EDGE_FALL, EDGE_BOTH) and the limits MAX_SYNC_STAGES=4 and MAX_FILTER=255.
REQ-032 Sub-module sync_chain, parametrised by depth, SHALL implement one channel's flop chain and be instantiated NUM_CH times via generate.
REQ-033 Parameter ranges SHALL be checked at elaboration time.

Verification
REQ-034 Defaults; i_async[0] rises and holds -> o_pulse[0] high for 1 cycle on edge 3, o_count[0]=1 and o_sticky[0]=1 one cycle later.
REQ-035 FILTER_CYCLES=3; a 2-cycle high glitch on channel 1 -> no pulse and count unchanged; a 6-cycle high -> one pulse, latency 6.
REQ-036 EDGE_MODE=EDGE_BOTH; rise then fall 10 cycles apart on channel 2 -> two pulses, o_count[2]=2.
REQ-037 CNT_W=2; 5 events -> o_count saturates at 3; i_clr coincident with a 6th event -> o_count=1, o_sticky=1.
REQ-038 All channels toggled in the same cycle -> all o_pulse bits assert in the same cycle.
REQ-039 Input held high across a reset pulse, with reset asserted mid-filter -> no pulse during reset, one pulse SYNC_STAGES+1+FILTER_CYCLES edges after release.
